// File: rtl/mem_responder_pkg.sv
// Shared constants for the tinycpu bus responder: I/O address map and STAT layout.
package mem_responder_pkg;

    localparam logic [7:0] ADDR_TXD  = 8'hF0;
    localparam logic [7:0] ADDR_STAT = 8'hF1;
    localparam logic [7:0] ADDR_IN   = 8'hF2;
    localparam logic [7:0] ADDR_CNT  = 8'hF3;

    localparam int STAT_OVF_BIT   = 7;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_EMPTY_BIT = 5;

    localparam int FIFO_DEPTH_DEFAULT = 8;

    function automatic logic [7:0] pack_stat(input logic ovf, input logic full,
                                             input logic empty, input logic [3:0] count);
        logic [7:0] s;
        s                 = '0;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        s[3:0]            = count;
        return s;
    endfunction

endpackage

// File: rtl/mem_responder_out_fifo.sv
// Output byte FIFO with registered head, element count and sticky overflow flag.
module out_fifo
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_req,
    input  logic       clear_ovf,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       full,
    output logic       empty,
    output logic [3:0] count,
    output logic       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [7:0]       mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic [3:0]       count_reg, count_next;
    logic [7:0]       out_data_reg;
    logic             overflow_reg;
    logic             pop, push_ok;

    assign empty     = (count_reg == 4'd0);
    assign full      = (count_reg == 4'(DEPTH));
    assign pop       = pop_req && !empty;
    assign push_ok   = push && (!full || pop);
    assign out_valid = !empty;
    assign out_data  = out_data_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok)
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        if (push_ok && !pop)
            count_next = count_reg + 4'd1;
        else if (pop && !push_ok)
            count_next = count_reg - 4'd1;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push_ok && wr_ptr_reg == PTR_W'(gi))
                mem[gi] <= push_data;
        end
    end

    // The head register is loaded with whatever will be at the head after this
    // edge; a byte pushed into an empty (or draining-to-empty) FIFO bypasses mem.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            out_data_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next != 4'd0) begin
                if (empty || (pop && count_reg == 4'd1))
                    out_data_reg <= push_data;
                else
                    out_data_reg <= mem[rd_ptr_next];
            end
            if (clear_ovf)
                overflow_reg <= 1'b0;
            else if (push && full && !pop)
                overflow_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// SRAM-style bus responder: RAM, TX FIFO, input port and cycle counter behind one bus.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [7:0] RAM_TOP    = 8'hDF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic       cen,
    input  logic       wen,
    input  logic       oen,
    inout  wire  [7:0] dq,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    logic [7:0] ram_mem [0:RAM_TOP];
    logic [7:0] cnt_reg;
    logic [7:0] rd_data;
    logic       strobe_prev_reg;
    logic       strobe_now, wr_pulse, in_ram, drive;
    logic       fifo_full, fifo_empty, fifo_ovf;
    logic [3:0] fifo_count;

    assign strobe_now = !cen && !wen;
    // Only the first sampled edge of a held strobe writes; reset suppresses it.
    assign wr_pulse   = strobe_now && !strobe_prev_reg && !reset;
    assign in_ram     = (addr <= RAM_TOP);
    assign drive      = !cen && !oen && wen && !reset;
    assign dq         = drive ? rd_data : 8'hzz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_prev_reg <= 1'b0;
            cnt_reg         <= 8'h00;
        end else begin
            strobe_prev_reg <= strobe_now;
            if (wr_pulse && addr == ADDR_CNT)
                cnt_reg <= dq;
            else
                cnt_reg <= cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_pulse && in_ram)
            ram_mem[addr] <= dq;
    end

    always_comb begin
        rd_data = 8'h00;
        if (in_ram) begin
            rd_data = ram_mem[addr];
        end else begin
            case (addr)
                ADDR_STAT: rd_data = pack_stat(fifo_ovf, fifo_full, fifo_empty, fifo_count);
                ADDR_IN:   rd_data = in_data;
                ADDR_CNT:  rd_data = cnt_reg;
                default:   rd_data = 8'h00;
            endcase
        end
    end

    out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_pulse && addr == ADDR_TXD),
        .push_data (dq),
        .pop_req   (out_ready),
        .clear_ovf (wr_pulse && addr == ADDR_STAT),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

endmodule
